// File: rtl/audio_frame_scheduler_pkg.sv
// rtl/audio_frame_scheduler_pkg.sv - shared types, constants and the saturating adder
// Contents: mode_e (MODE_A/MODE_B/MODE_SUM/MODE_MUTE), state_e (ST_PRIME/ST_RUN),
//           SAT_MAX/SAT_MIN clamp limits, sat_add() per-channel saturating sum.
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_A    = 2'd0,
        MODE_B    = 2'd1,
        MODE_SUM  = 2'd2,
        MODE_MUTE = 2'd3
    } mode_e;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int SMP_W  = 15;
    localparam int PAIR_W = 2 * SMP_W;

    localparam logic signed [15:0] SAT_MAX = 16'sd16383;
    localparam logic signed [15:0] SAT_MIN = -16'sd16384;

    // Two 15-bit samples always fit a 16-bit sum, so clamping that sum is exact.
    function automatic logic [SMP_W-1:0] sat_add(input logic [SMP_W-1:0] x,
                                                 input logic [SMP_W-1:0] y);
        logic signed [15:0] s;
        s = $signed({x[SMP_W-1], x}) + $signed({y[SMP_W-1], y});
        if (s > SAT_MAX)
            s = SAT_MAX;
        else if (s < SAT_MIN)
            s = SAT_MIN;
        return s[SMP_W-1:0];
    endfunction

endpackage

// File: rtl/audio_frame_scheduler_if.sv
// rtl/audio_frame_scheduler_if.sv - producer, frame-timing and shifter signals of the scheduler
// Signals: frame_sync, mode, urun_clr; source A/B valid/ready/ldata/rdata;
//          ldata/rdata to the shifter; a_urun_cnt/b_urun_cnt.
// Modports: slave = scheduler side, master = producer/shifter/control side.
interface audio_frame_scheduler_if;
    logic        frame_sync;
    logic [1:0]  mode;
    logic        urun_clr;
    logic        a_valid;
    logic        a_ready;
    logic [14:0] a_ldata;
    logic [14:0] a_rdata;
    logic        b_valid;
    logic        b_ready;
    logic [14:0] b_ldata;
    logic [14:0] b_rdata;
    logic [14:0] ldata;
    logic [14:0] rdata;
    logic [7:0]  a_urun_cnt;
    logic [7:0]  b_urun_cnt;

    modport slave (
        input  frame_sync, mode, urun_clr,
        input  a_valid, a_ldata, a_rdata,
        input  b_valid, b_ldata, b_rdata,
        output a_ready, b_ready, ldata, rdata, a_urun_cnt, b_urun_cnt
    );

    modport master (
        output frame_sync, mode, urun_clr,
        output a_valid, a_ldata, a_rdata,
        output b_valid, b_ldata, b_rdata,
        input  a_ready, b_ready, ldata, rdata, a_urun_cnt, b_urun_cnt
    );
endinterface

// File: rtl/audio_frame_scheduler_fifo.sv
// rtl/audio_frame_scheduler_fifo.sv - per-source stereo sample FIFO with registered count
// Ports: clk, nreset; push/push_data (write); pop/head (read, head valid when count != 0);
//        full and count, both derived from the registered count.
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full comes only from the stored count, so a pop in this cycle cannot
    // make room for a push in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && nreset)
            mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/audio_frame_scheduler.sv
// rtl/audio_frame_scheduler.sv - frame-paced mixer feeding the serial audio output shifter
// Ports: clk, nreset (sync, active-low); s (slave modport) carrying frame_sync, mode,
//        urun_clr, source A/B sample handshakes, held ldata/rdata and underrun counters.
// Parameters: DEPTH (FIFO depth), PRIME_LVL (fill level to start), HOLD_LAST (underrun output).
module audio_frame_scheduler
    import audio_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PRIME_LVL = 2,
    parameter int HOLD_LAST = 1
) (
    input  logic                     clk,
    input  logic                     nreset,
    audio_frame_scheduler_if.slave   s
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e              state, state_n;
    mode_e               mode_q, mode_n, mode_in;
    logic [SMP_W-1:0]    ldata_n, rdata_n;
    logic [PAIR_W-1:0]   a_head, b_head;
    logic [CW-1:0]       a_count, b_count;
    logic                a_full, b_full;
    logic                pop_a, pop_b, urun_a, urun_b;
    logic                sel_a, sel_b;
    logic                a_empty, b_empty, a_primed, b_primed;
    logic                fs_q;

    assign s.a_ready = nreset && !a_full;
    assign s.b_ready = nreset && !b_full;

    audio_sample_fifo #(.DEPTH(DEPTH), .WIDTH(PAIR_W)) u_fifo_a (
        .clk       (clk),
        .nreset    (nreset),
        .push      (s.a_valid && s.a_ready),
        .push_data ({s.a_ldata, s.a_rdata}),
        .pop       (pop_a),
        .head      (a_head),
        .full      (a_full),
        .count     (a_count)
    );

    audio_sample_fifo #(.DEPTH(DEPTH), .WIDTH(PAIR_W)) u_fifo_b (
        .clk       (clk),
        .nreset    (nreset),
        .push      (s.b_valid && s.b_ready),
        .push_data ({s.b_ldata, s.b_rdata}),
        .pop       (pop_b),
        .head      (b_head),
        .full      (b_full),
        .count     (b_count)
    );

    // Every decision uses the mode being sampled at this frame_sync, so the
    // PRIME check of the first frame already sees the newly requested sources.
    assign mode_in  = mode_e'(s.mode);
    assign sel_a    = (mode_in == MODE_A) || (mode_in == MODE_SUM);
    assign sel_b    = (mode_in == MODE_B) || (mode_in == MODE_SUM);
    assign a_empty  = (a_count == '0);
    assign b_empty  = (b_count == '0);
    assign a_primed = (a_count >= CW'(PRIME_LVL));
    assign b_primed = (b_count >= CW'(PRIME_LVL));

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        ldata_n = s.ldata;
        rdata_n = s.rdata;
        pop_a   = 1'b0;
        pop_b   = 1'b0;
        urun_a  = 1'b0;
        urun_b  = 1'b0;
        if (s.frame_sync) begin
            mode_n  = mode_in;
            ldata_n = '0;
            rdata_n = '0;
            case (state)
                ST_PRIME: begin
                    if (mode_in == MODE_MUTE ||
                        ((!sel_a || a_primed) && (!sel_b || b_primed)))
                        state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (mode_in != mode_q) begin
                        state_n = ST_PRIME;
                    end else if ((sel_a && a_empty) || (sel_b && b_empty)) begin
                        // Neither source is popped on an underrun so A and B stay aligned.
                        urun_a  = sel_a && a_empty;
                        urun_b  = sel_b && b_empty;
                        state_n = ST_PRIME;
                        if (HOLD_LAST != 0) begin
                            ldata_n = s.ldata;
                            rdata_n = s.rdata;
                        end
                    end else begin
                        pop_a = sel_a;
                        pop_b = sel_b;
                        case (mode_q)
                            MODE_A: begin
                                ldata_n = a_head[PAIR_W-1:SMP_W];
                                rdata_n = a_head[SMP_W-1:0];
                            end
                            MODE_B: begin
                                ldata_n = b_head[PAIR_W-1:SMP_W];
                                rdata_n = b_head[SMP_W-1:0];
                            end
                            MODE_SUM: begin
                                ldata_n = sat_add(a_head[PAIR_W-1:SMP_W], b_head[PAIR_W-1:SMP_W]);
                                rdata_n = sat_add(a_head[SMP_W-1:0], b_head[SMP_W-1:0]);
                            end
                            default: begin
                                ldata_n = '0;
                                rdata_n = '0;
                            end
                        endcase
                    end
                end
                default: state_n = ST_PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= ST_PRIME;
            mode_q  <= MODE_MUTE;
            s.ldata <= '0;
            s.rdata <= '0;
            fs_q    <= 1'b0;
        end else begin
            state   <= state_n;
            mode_q  <= mode_n;
            s.ldata <= ldata_n;
            s.rdata <= rdata_n;
            fs_q    <= s.frame_sync;
        end
    end

    // Clear beats a coincident underrun; both counters stick at 255.
    always_ff @(posedge clk) begin
        if (!nreset || s.urun_clr) begin
            s.a_urun_cnt <= '0;
            s.b_urun_cnt <= '0;
        end else begin
            if (urun_a && s.a_urun_cnt != 8'hFF)
                s.a_urun_cnt <= s.a_urun_cnt + 8'd1;
            if (urun_b && s.b_urun_cnt != 8'hFF)
                s.b_urun_cnt <= s.b_urun_cnt + 8'd1;
        end
    end

    // Back-to-back frame_sync pulses would break the one-frame hold contract.
    always @(posedge clk) begin
        if (nreset)
            assert (!(s.frame_sync && fs_q));
    end
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb/tb_audio_frame_scheduler.sv - directed table and sequence bench for audio_frame_scheduler
module tb_audio_frame_scheduler;
    logic clk = 1'b0;
    logic nreset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    audio_frame_scheduler_if u0_if ();
    audio_frame_scheduler_if u1_if ();

    // Second instance sees identical stimulus but zeroes its output on underrun.
    assign u1_if.frame_sync = u0_if.frame_sync;
    assign u1_if.mode       = u0_if.mode;
    assign u1_if.urun_clr   = u0_if.urun_clr;
    assign u1_if.a_valid    = u0_if.a_valid;
    assign u1_if.a_ldata    = u0_if.a_ldata;
    assign u1_if.a_rdata    = u0_if.a_rdata;
    assign u1_if.b_valid    = u0_if.b_valid;
    assign u1_if.b_ldata    = u0_if.b_ldata;
    assign u1_if.b_rdata    = u0_if.b_rdata;

    audio_frame_scheduler #(.DEPTH(4), .PRIME_LVL(2), .HOLD_LAST(1)) u_dut0 (
        .clk    (clk),
        .nreset (nreset),
        .s      (u0_if)
    );

    audio_frame_scheduler #(.DEPTH(4), .PRIME_LVL(2), .HOLD_LAST(0)) u_dut1 (
        .clk    (clk),
        .nreset (nreset),
        .s      (u1_if)
    );

    typedef struct {
        logic [1:0] mode;
        int al, ar, bl, br;
        int el, er;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        u0_if.frame_sync = 1'b0;
        u0_if.a_valid = 1'b0;
        u0_if.b_valid = 1'b0;
        u0_if.urun_clr = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic push_a(input int l, input int r);
        @(negedge clk);
        u0_if.a_valid = 1'b1;
        u0_if.a_ldata = 15'(l);
        u0_if.a_rdata = 15'(r);
        @(negedge clk);
        u0_if.a_valid = 1'b0;
    endtask

    task automatic push_b(input int l, input int r);
        @(negedge clk);
        u0_if.b_valid = 1'b1;
        u0_if.b_ldata = 15'(l);
        u0_if.b_rdata = 15'(r);
        @(negedge clk);
        u0_if.b_valid = 1'b0;
    endtask

    task automatic sync(input logic clr);
        @(negedge clk);
        u0_if.frame_sync = 1'b1;
        u0_if.urun_clr = clr;
        @(negedge clk);
        u0_if.frame_sync = 1'b0;
        u0_if.urun_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd0,    100,   -100,     0,     0,    100,   -100};
        vecs[1] = '{2'd1,      5,      5,     7,    -7,      7,     -7};
        vecs[2] = '{2'd2,  16000,  16000,  1000,  1000,  16383,  16383};
        vecs[3] = '{2'd2, -16000, -16000, -1000, -1000, -16384, -16384};
        vecs[4] = '{2'd2,  16383, -16384,     1,    -1,  16383, -16384};
        vecs[5] = '{2'd2,    300,   -200,  -100,    50,    200,   -150};
        vecs[6] = '{2'd3,      5,      5,     5,     5,      0,      0};

        nreset = 1'b0;
        u0_if.frame_sync = 1'b0;
        u0_if.mode = 2'd0;
        u0_if.urun_clr = 1'b0;
        u0_if.a_valid = 1'b0;
        u0_if.b_valid = 1'b0;
        u0_if.a_ldata = '0;
        u0_if.a_rdata = '0;
        u0_if.b_ldata = '0;
        u0_if.b_rdata = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_a_ready", int'(u0_if.a_ready), 0);
        chk("rst_b_ready", int'(u0_if.b_ready), 0);
        chk("rst_ldata", int'(u0_if.ldata), 0);
        chk("rst_rdata", int'(u0_if.rdata), 0);
        chk("rst_a_cnt", int'(u0_if.a_urun_cnt), 0);
        chk("rst_b_cnt", int'(u0_if.b_urun_cnt), 0);
        nreset = 1'b1;
        @(negedge clk);
        chk("post_rst_a_ready", int'(u0_if.a_ready), 1);
        chk("post_rst_b_ready", int'(u0_if.b_ready), 1);
        chk("post_rst_u1_ready", int'(u1_if.a_ready && u1_if.b_ready), 1);

        // Table: prime both FIFOs, PRIME->RUN, then one popped frame
        for (int i = 0; i < 7; i++) begin
            do_reset();
            u0_if.mode = vecs[i].mode;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                u0_if.a_valid = 1'b1;
                u0_if.a_ldata = 15'(vecs[i].al);
                u0_if.a_rdata = 15'(vecs[i].ar);
                u0_if.b_valid = 1'b1;
                u0_if.b_ldata = 15'(vecs[i].bl);
                u0_if.b_rdata = 15'(vecs[i].br);
                @(negedge clk);
                u0_if.a_valid = 1'b0;
                u0_if.b_valid = 1'b0;
            end
            sync(1'b0);
            chk($sformatf("vec%0d_prime_l", i), $signed(u0_if.ldata), 0);
            sync(1'b0);
            chk($sformatf("vec%0d_l", i), $signed(u0_if.ldata), vecs[i].el);
            chk($sformatf("vec%0d_r", i), $signed(u0_if.rdata), vecs[i].er);
            chk($sformatf("vec%0d_u1_l", i), $signed(u1_if.ldata), vecs[i].el);
        end

        // Full FIFO, blocked 5th push, drain, underrun with hold/zero
        do_reset();
        u0_if.mode = 2'd0;
        for (int k = 1; k <= 4; k++)
            push_a(k, -k);
        chk("full_a_ready", int'(u0_if.a_ready), 0);
        push_a(5, -5);
        chk("full_a_ready_after5", int'(u0_if.a_ready), 0);
        sync(1'b0);
        for (int k = 1; k <= 4; k++) begin
            sync(1'b0);
            chk($sformatf("drain%0d_l", k), $signed(u0_if.ldata), k);
            chk($sformatf("drain%0d_r", k), $signed(u0_if.rdata), -k);
        end
        sync(1'b0);
        chk("urun_hold_l", $signed(u0_if.ldata), 4);
        chk("urun_hold_r", $signed(u0_if.rdata), -4);
        chk("urun_cnt", int'(u0_if.a_urun_cnt), 1);
        chk("urun_zero_l", $signed(u1_if.ldata), 0);
        chk("urun_zero_r", $signed(u1_if.rdata), 0);
        chk("urun_u1_cnt", int'(u1_if.a_urun_cnt), 1);
        sync(1'b0);
        chk("prime_after_urun_l", $signed(u0_if.ldata), 0);
        chk("prime_after_urun_cnt", int'(u0_if.a_urun_cnt), 1);
        push_a(9, -9);
        push_a(9, -9);
        sync(1'b0);
        sync(1'b0);
        chk("reprime_l", $signed(u0_if.ldata), 9);

        // Mode change mid-frame: held until frame_sync, then PRIME until B primed
        @(negedge clk);
        u0_if.mode = 2'd1;
        repeat (3) @(negedge clk);
        chk("midframe_hold_l", $signed(u0_if.ldata), 9);
        sync(1'b0);
        chk("modechg_l", $signed(u0_if.ldata), 0);
        push_b(20, -20);
        sync(1'b0);
        chk("b_under_prime_l", $signed(u0_if.ldata), 0);
        push_b(21, -21);
        sync(1'b0);
        chk("b_primed_l", $signed(u0_if.ldata), 0);
        sync(1'b0);
        chk("b_run_l", $signed(u0_if.ldata), 20);
        chk("b_run_r", $signed(u0_if.rdata), -20);
        chk("b_run_a_cnt", int'(u0_if.a_urun_cnt), 1);
        chk("b_run_b_cnt", int'(u0_if.b_urun_cnt), 0);

        // Counter saturation, clear vs coincident underrun, reset mid-RUN
        do_reset();
        u0_if.mode = 2'd0;
        for (int n = 0; n < 300; n++) begin
            push_a(n, n);
            push_a(n, n);
            repeat (4) sync(1'b0);
        end
        chk("sat_a_cnt", int'(u0_if.a_urun_cnt), 255);
        chk("sat_b_cnt", int'(u0_if.b_urun_cnt), 0);
        push_a(1, 1);
        push_a(1, 1);
        repeat (3) sync(1'b0);
        sync(1'b1);
        chk("clr_wins_cnt", int'(u0_if.a_urun_cnt), 0);
        chk("clr_wins_u1_cnt", int'(u1_if.a_urun_cnt), 0);
        push_a(77, -77);
        push_a(78, -78);
        sync(1'b0);
        sync(1'b0);
        chk("pre_rst_l", $signed(u0_if.ldata), 77);
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        chk("midrun_rst_l", $signed(u0_if.ldata), 0);
        chk("midrun_rst_r", $signed(u0_if.rdata), 0);
        chk("midrun_rst_ready", int'(u0_if.a_ready), 0);
        chk("midrun_rst_u1_bcnt", int'(u1_if.b_urun_cnt), 0);
        nreset = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
